debounce_arbiter: RTL and testbench

- Debounces NUM_BUTTONS raw button inputs using one shared stability counter instead of one counter per button.
- A round-robin scheduler grants the counter to one unstable input at a time.
- Per-button stable levels and one-cycle press/release pulses feed the application logic.
- Sits between the board button pins and the LED/UART control logic.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_sync2.sv | 24 ++
 rtl/debounce_arbiter.sv | 139 +++++++++++++
 tb/tb_debounce_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the shared-counter button debouncer:
// FSM state encoding, default stability count and a width helper.
package debounce_pkg;

    // Arbiter FSM: waiting for a mismatch, or counting for one owner.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // 250000 cycles is about 5 ms at a 50 MHz board clock.
    localparam int DEF_MAX_COUNT = 250000;

    // Ceiling log2, for sizing counters and index fields.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/debounce_sync2.sv
// Parameterised-width two-flop synchronizer with async active-low reset.
// Ports: clk, rst_n, d (async levels), q (synchronized levels, 2-cycle delay).
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_arbiter.sv
// Debounces NUM_BUTTONS raw inputs with one shared stability counter,
// granted round-robin to one unstable input at a time.
// Ports: CLK, i_RST_N (async active-low), i_BUT (raw levels),
//        o_BUT (stable levels), o_PRESS / o_RELEASE (1-cycle edge pulses),
//        o_BUSY (counter granted), o_OWNER (current/last granted index).
module debounce_arbiter
    import debounce_pkg::*;
#(
    parameter int NUM_BUTTONS = 4,
    parameter int MAX_COUNT   = DEF_MAX_COUNT,
    parameter int CNT_WIDTH   = 18,
    parameter int IDX_WIDTH   = 2
) (
    input  logic                   CLK,
    input  logic                   i_RST_N,
    input  logic [NUM_BUTTONS-1:0] i_BUT,
    output logic [NUM_BUTTONS-1:0] o_BUT,
    output logic [NUM_BUTTONS-1:0] o_PRESS,
    output logic [NUM_BUTTONS-1:0] o_RELEASE,
    output logic                   o_BUSY,
    output logic [IDX_WIDTH-1:0]   o_OWNER
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_COUNT - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_BUTTONS - 1);

    // First set bit of req, scanning start+1, start+2, ... with wrap.
    function automatic logic [IDX_WIDTH-1:0] rr_pick(
        input logic [NUM_BUTTONS-1:0] req,
        input logic [IDX_WIDTH-1:0]   start
    );
        logic [IDX_WIDTH-1:0] pick;
        logic [IDX_WIDTH-1:0] idx;
        logic                 found;
        pick  = start;
        found = 1'b0;
        for (int k = 1; k <= NUM_BUTTONS; k++) begin
            idx = IDX_WIDTH'((int'(start) + k) % NUM_BUTTONS);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    logic [NUM_BUTTONS-1:0] sync;
    logic [NUM_BUTTONS-1:0] mismatch;
    logic [IDX_WIDTH-1:0]   grant_idx;

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   count, count_nxt;
    logic [IDX_WIDTH-1:0]   owner, owner_nxt;
    logic [IDX_WIDTH-1:0]   last, last_nxt;
    logic [NUM_BUTTONS-1:0] but_q, but_nxt;
    logic [NUM_BUTTONS-1:0] press_q, press_nxt;
    logic [NUM_BUTTONS-1:0] release_q, release_nxt;

    sync2 #(
        .WIDTH(NUM_BUTTONS)
    ) u_sync (
        .clk  (CLK),
        .rst_n(i_RST_N),
        .d    (i_BUT),
        .q    (sync)
    );

    assign mismatch  = sync ^ but_q;
    assign grant_idx = rr_pick(mismatch, last);

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        owner_nxt   = owner;
        last_nxt    = last;
        but_nxt     = but_q;
        press_nxt   = '0;
        release_nxt = '0;
        unique case (state)
            ST_IDLE: begin
                if (|mismatch) begin
                    owner_nxt = grant_idx;
                    last_nxt  = grant_idx;
                    count_nxt = '0;
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (sync[owner] == but_q[owner]) begin
                    // Glitch: owner went back; last already points at it,
                    // so the next search favours the other requesters.
                    count_nxt = '0;
                    state_nxt = ST_IDLE;
                end else if (count == CNT_LAST) begin
                    but_nxt[owner] = sync[owner];
                    if (sync[owner]) begin
                        press_nxt[owner] = 1'b1;
                    end else begin
                        release_nxt[owner] = 1'b1;
                    end
                    count_nxt = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    count_nxt = count + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state     <= ST_IDLE;
            count     <= '0;
            owner     <= '0;
            last      <= IDX_LAST;
            but_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            owner     <= owner_nxt;
            last      <= last_nxt;
            but_q     <= but_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
        end
    end

    assign o_BUT     = but_q;
    assign o_PRESS   = press_q;
    assign o_RELEASE = release_q;
    assign o_BUSY    = (state == ST_COUNT);
    assign o_OWNER   = owner;

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed bench for debounce_arbiter with MAX_COUNT=8, 4 buttons.
// Timing: input edge -> commit on the 11th rising edge (2 sync + 1 + 8).
module tb_debounce_arbiter;

    localparam int NB = 4;
    localparam int MC = 8;
    localparam int CW = 18;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] but_in;
    logic [NB-1:0] but_out;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic          busy;
    logic [IW-1:0] owner;

    int errors = 0;
    int checks = 0;
    int tcount;
    int multi;
    int press_at[NB];
    int rel_at[NB];

    debounce_arbiter #(
        .NUM_BUTTONS(NB),
        .MAX_COUNT  (MC),
        .CNT_WIDTH  (CW),
        .IDX_WIDTH  (IW)
    ) dut (
        .CLK      (clk),
        .i_RST_N  (rst_n),
        .i_BUT    (but_in),
        .o_BUT    (but_out),
        .o_PRESS  (press),
        .o_RELEASE(rel),
        .o_BUSY   (busy),
        .o_OWNER  (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        tcount = 0;
        multi  = 0;
        for (int i = 0; i < NB; i++) begin
            press_at[i] = -1;
            rel_at[i]   = -1;
        end
    endtask

    // Advance n rising edges, sampling 1 time unit after each edge and
    // logging the first edge number on which each pulse bit was seen.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            tcount++;
            for (int i = 0; i < NB; i++) begin
                if (press[i] && press_at[i] < 0) press_at[i] = tcount;
                if (rel[i] && rel_at[i] < 0) rel_at[i] = tcount;
            end
            if ($countones({press, rel}) > 1) multi++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run(2);
        @(negedge clk);
        rst_n = 1'b1;
        run(2);
    endtask

    initial begin
        clear_log();
        rst_n  = 1'b0;
        but_in = 4'b1111;
        run(3);
        check("rst_but", but_out, 4'b0000);
        check("rst_press", press, 4'b0000);
        check("rst_rel", rel, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 2'd0);

        @(negedge clk);
        rst_n = 1'b1;
        run(3);
        check("first_busy", busy, 1'b1);
        check("first_owner", owner, 2'd0);

        but_in = 4'b0000;
        do_reset();
        check("idle_busy", busy, 1'b0);

        clear_log();
        but_in = 4'b0010;
        run(10);
        check("press_early", but_out, 4'b0000);
        run(1);
        check("press_but", but_out, 4'b0010);
        check("press_pulse", press, 4'b0010);
        check("press_rel", rel, 4'b0000);
        run(1);
        check("press_once", press, 4'b0000);
        check("press_lat", press_at[1], 11);

        clear_log();
        but_in = 4'b0000;
        run(12);
        check("rel_lat", rel_at[1], 11);
        check("rel_but", but_out, 4'b0000);
        check("rel_nopress", press_at[1], -1);

        clear_log();
        but_in = 4'b0100;
        run(5);
        but_in = 4'b0000;
        run(10);
        check("glitch_nopulse", press_at[2], -1);
        check("glitch_but", but_out, 4'b0000);
        check("glitch_idle", busy, 1'b0);

        clear_log();
        but_in = 4'b0100;
        run(12);
        check("long_lat", press_at[2], 11);
        check("long_but", but_out, 4'b0100);
        but_in = 4'b0000;
        run(12);
        check("long_back", but_out, 4'b0000);

        do_reset();
        clear_log();
        but_in = 4'b1111;
        run(40);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("sim_lat%0d", i), press_at[i], 11 + 9 * i);
        end
        check("sim_onehot", multi, 0);
        check("sim_but", but_out, 4'b1111);

        clear_log();
        but_in = 4'b0110;
        run(3);
        check("fair1_owner", owner, 2'd0);
        check("fair1_busy", busy, 1'b1);
        run(22);
        check("fair1_rel0", rel_at[0], 11);
        check("fair1_rel3", rel_at[3], 20);
        check("fair1_but", but_out, 4'b0110);

        clear_log();
        but_in = 4'b0010;
        run(12);
        check("fair2_setup", rel_at[2], 11);
        clear_log();
        but_in = 4'b1011;
        run(3);
        check("fair2_owner", owner, 2'd3);
        run(22);
        check("fair2_p3", press_at[3], 11);
        check("fair2_p0", press_at[0], 20);
        check("fair2_but", but_out, 4'b1011);

        clear_log();
        but_in = 4'b1111;
        run(8);
        check("mid_busy", busy, 1'b1);
        check("mid_owner", owner, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_but", but_out, 4'b0000);
        check("async_busy", busy, 1'b0);
        check("async_owner", owner, 2'd0);
        check("async_press", press, 4'b0000);
        run(2);
        check("async_nopulse", press_at[1], -1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        run(12);
        check("restart_lat", press_at[0], 11);
        check("restart_p1", press_at[1], -1);
        check("restart_onehot", multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
